// File: rtl/fib_pkg.sv
// Shared types and helpers for the recursive-sequence stack engine.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_POP   = 2'd2,
    OP_SPLIT = 2'd3
  } lifo_op_e;

  localparam int DATA_W_DEFAULT = 16;
  localparam logic [DATA_W_DEFAULT-1:0] SAT_MAX = {DATA_W_DEFAULT{1'b1}};

  // Deepest stack occupancy reached while expanding the tree for argument n.
  function automatic int unsigned peak_depth(input int unsigned n);
    return (n / 32'd2) + 32'd1;
  endfunction

  function automatic logic needs_overflow(input int unsigned n, input int unsigned depth);
    return (peak_depth(n) > depth);
  endfunction

endpackage

// File: rtl/fib_lifo.sv
// Node stack for the tree traversal: load, pop and replace-top-and-push, one per cycle.
module fib_lifo
  import fib_pkg::*;
#(
  parameter int N_W         = 5,
  parameter int STACK_DEPTH = 16,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  lifo_op_e        op,
  input  logic [N_W-1:0]  load_val,
  input  logic [N_W-1:0]  top_new,
  input  logic [N_W-1:0]  push_val,
  output logic [N_W-1:0]  top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [N_W-1:0]   mem_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  sp_d;
  logic [SP_W-1:0]  sp_m1_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [IDX_W-1:0] push_idx_s;

  assign sp_m1_s    = sp_q - SP_W'(1);
  assign top_idx_s  = sp_m1_s[IDX_W-1:0];
  assign push_idx_s = sp_q[IDX_W-1:0];
  assign full       = (sp_q == SP_W'(STACK_DEPTH));
  assign empty      = (sp_q == {SP_W{1'b0}});
  assign sp         = sp_q;
  assign top        = empty ? {N_W{1'b0}} : mem_q[top_idx_s];

  // Stack pointer next value; illegal ops on full/empty leave it untouched.
  always_comb begin
    sp_d = sp_q;
    case (op)
      OP_LOAD: sp_d = SP_W'(1);
      OP_POP: begin
        if (!empty) begin
          sp_d = sp_m1_s;
        end else begin
          sp_d = sp_q;
        end
      end
      OP_SPLIT: begin
        if (!full && !empty) begin
          sp_d = sp_q + SP_W'(1);
        end else begin
          sp_d = sp_q;
        end
      end
      default: sp_d = sp_q;
    endcase
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= {SP_W{1'b0}};
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage; a split on a full stack writes nothing so contents survive an abort.
  always_ff @(posedge clk) begin
    case (op)
      OP_LOAD: mem_q[0] <= load_val;
      OP_SPLIT: begin
        if (!full && !empty) begin
          mem_q[top_idx_s]  <= top_new;
          mem_q[push_idx_s] <= push_val;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fib_stack_engine.sv
// Recursive-sequence engine: walks the f(n)=f(n-1)+f(n-2) call tree on a LIFO,
// summing base values at the leaves with a saturating accumulator.
module fib_stack_engine
  import fib_pkg::*;
#(
  parameter int N_W         = 5,
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  input  logic [DATA_W-1:0] base0,
  input  logic [DATA_W-1:0] base1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              err
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DATA_W-1:0] ACC_MAX = {DATA_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] base0_q, base0_d;
  logic [DATA_W-1:0] base1_q, base1_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  lifo_op_e          op_s;
  logic [N_W-1:0]    top_s;
  logic [SP_W-1:0]   sp_s;
  logic              full_s;
  logic              empty_s;
  logic              is_leaf_s;
  logic [DATA_W-1:0] leaf_val_s;
  logic [DATA_W:0]   sum_s;

  fib_lifo #(
    .N_W        (N_W),
    .STACK_DEPTH(STACK_DEPTH),
    .SP_W       (SP_W)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .op      (op_s),
    .load_val(n),
    .top_new (top_s - N_W'(1)),
    .push_val(top_s - N_W'(2)),
    .top     (top_s),
    .sp      (sp_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign is_leaf_s  = (top_s[N_W-1:1] == {(N_W-1){1'b0}});
  assign leaf_val_s = top_s[0] ? base1_q : base0_q;
  assign sum_s      = {1'b0, acc_q} + {1'b0, leaf_val_s};

  // Next-state, accumulator and stack-operation decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base0_d  = base0_q;
    base1_d  = base1_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    op_s     = OP_NONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          op_s    = OP_LOAD;
          acc_d   = {DATA_W{1'b0}};
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          base0_d = base0;
          base1_d = base1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (empty_s) begin
          state_d  = DONE;
          result_d = acc_q;
        end else if (is_leaf_s) begin
          op_s  = OP_POP;
          acc_d = sum_s[DATA_W] ? ACC_MAX : sum_s[DATA_W-1:0];
          ovf_d = ovf_q | sum_s[DATA_W];
          if (sp_s == SP_W'(1)) begin
            state_d  = DONE;
            result_d = acc_d;
          end else begin
            state_d = RUN;
          end
        end else if (!full_s) begin
          op_s    = OP_SPLIT;
          state_d = RUN;
        end else begin
          // Expansion would need one more entry than exists: abort with the partial sum.
          err_d    = 1'b1;
          result_d = acc_q;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= {DATA_W{1'b0}};
      base0_q  <= {DATA_W{1'b0}};
      base1_q  <= {DATA_W{1'b0}};
      result_q <= {DATA_W{1'b0}};
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base0_q  <= base0_d;
      base1_q  <= base1_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: doc/fib_stack_engine.md
# fib_stack_engine

Parametrised recursive-sequence engine: evaluates f(n) = f(n-1) + f(n-2) with programmable bases f(0)=BASE0, f(1)=BASE1 (Fibonacci, Lucas, …) by true recursive tree traversal over an internal LIFO. It is the generalised successor of the fixed-width Fibonacci stack controller. It adds a start/done handshake, parametric widths and stack depth, saturating arithmetic, and stack-overflow detection. It sits as a compute slave under the top-level sequencer.

## Interface
- N_W, default 5: width of the argument n.
- DATA_W, default 16: width of the bases, the accumulator and the result.
- STACK_DEPTH, default 16: number of LIFO entries, each N_W bits wide.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- n  in  N_W  argument. Captured on the start-accept edge.
- base0  in  DATA_W  f(0). Captured on the start-accept edge.
- base1  in  DATA_W  f(1). Captured on the start-accept edge.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse while in DONE.
- result  out  DATA_W  final sum. Held from DONE until the next accept.
- ovf  out  1  accumulator saturated during this run. Held with result.
- err  out  1  stack overflow aborted this run. Held with result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - On that edge: stack[0]←n, sp←1, acc←0, ovf←0, err←0, and the bases are latched.
  - Otherwise stay in IDLE.
- RUN: each cycle processes one tree node, x = top of stack.
  - x<2:
    - acc ← acc + (x==0 ? base0 : base1), saturating at 2^DATA_W−1.
    - Saturation sets ovf.
    - Pop: sp←sp−1.
    - sp reaching 0 → DONE, with result←final acc.
  - x≥2, sp<STACK_DEPTH:
    - Replace the top with x−1 and push x−2, in the same cycle: sp←sp+1.
  - x≥2, sp==STACK_DEPTH:
    - err←1, result←acc (partial sum) → DONE.
    - No push occurs and the stack is not corrupted.
- DONE: done=1 for exactly one cycle, then → IDLE.
- start while busy is ignored; it is neither queued nor counted.
- Changes on n, base0 or base1 after the accept edge have no effect on the current run.
- Saturation does not stop traversal; the run completes with result=2^DATA_W−1 and ovf=1.
- Depth requirement: the peak sp for argument n is floor(n/2)+1. err fires iff this exceeds STACK_DEPTH.

## Timing
- Reset values: state IDLE, sp=0, acc=0, busy=0, done=0, result=0, ovf=0, err=0.
- Reset asserted mid-run wins over everything. On the next edge every value returns to its reset value, with no done pulse.
- Node count K(n) = 2·F(n+1) − 1, with standard F(1)=F(2)=1. This gives K(0)=K(1)=1 and K(10)=177.
- Latency: the accept is the edge at cycle t.
  - RUN occupies cycles t+1 … t+K.
  - done is high in cycle t+K+1.
  - busy rises in cycle t+1 and falls after the done cycle.
- Throughput: a new start is accepted no earlier than cycle t+K+2. Back-to-back runs are therefore separated by exactly one IDLE cycle.
- The err path ends RUN in the cycle that detects sp==STACK_DEPTH with x≥2. done follows in the next cycle.
- result, ovf and err are valid and stable in the done cycle, and stay stable through IDLE until the next accept clears ovf and err.

## Structure
- Shared package fib_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam SAT_MAX function of DATA_W;
  - helper function for the peak-depth calculation.
- Sub-module fib_lifo, parametrised by N_W and STACK_DEPTH.
  - Operations: load (sp←1), pop, replace-top-and-push.
  - Outputs: top, sp, full, empty.
  - All operations are single-cycle and mutually exclusive.
- fib_stack_engine contains the FSM, the saturating accumulator and the result/flag registers.

## Test plan
- Fibonacci: base0=0, base1=1, n=10 → result=55, ovf=0, err=0, done exactly 178 cycles after the accept edge.
- Lucas and the n=0 corner:
  - base0=2, base1=1, n=5 → result=11 after K=15.
  - n=0 → result=2, done 2 cycles after accept.
- Saturation: DATA_W=8, Fibonacci bases.
  - n=13 → result=233, ovf=0.
  - n=14 → result=255, ovf=1, err=0, full K=1219 traversal.
- Stack overflow:
  - STACK_DEPTH=4, n=8 (needs 5) → err=1, done asserted, no memory corruption.
  - A following run with n=6 (needs 4) → result=8, err=0.
- Handshake: pulse start during RUN and toggle n mid-run → the extra start is ignored and result matches the originally latched n. Back-to-back starts are accepted with a one-cycle IDLE gap.
- Reset mid-run: assert rst at cycle t+20 of an n=10 run → all outputs 0 next cycle, no done pulse. A fresh start then completes correctly.
